fir_mac_accumulator: RTL and testbench

// Consumer end of the polyphase decimator sample/coeff stream. Takes the per-lane sample and

---
 rtl/fir_mac_accumulator_if.sv | 30 +++
 rtl/fir_mac_accumulator.sv | 175 +++++++++++++++++
 tb/tb_fir_mac_accumulator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_accumulator_if.sv
// Tap stream (sample/coeff per lane) into the FIR MAC accumulator and the decimated result out.
// master drives the tap stream; slave is the accumulator.
interface fir_mac_accumulator_if #(
  parameter int SAMPLE_SIZE = 16,
  parameter int COEFF_SIZE  = 16,
  parameter int MAC_NUM     = 1,
  parameter int OUT_SIZE    = 16
);
  logic                           in_valid;
  logic                           in_last;
  logic                           in_ch;
  logic [SAMPLE_SIZE*MAC_NUM-1:0] s_in;
  logic [COEFF_SIZE*MAC_NUM-1:0]  c_in;
  logic                           busy;
  logic                           y_valid;
  logic [OUT_SIZE-1:0]            y_out;
  logic                           y_ch;
  logic                           len_err;
  logic                           overrun;

  modport master (
    output in_valid, in_last, in_ch, s_in, c_in,
    input  busy, y_valid, y_out, y_ch, len_err, overrun
  );

  modport slave (
    input  in_valid, in_last, in_ch, s_in, c_in,
    output busy, y_valid, y_out, y_ch, len_err, overrun
  );
endinterface

// File: rtl/fir_mac_accumulator.sv
// Per-lane multiply-accumulate over one decimation frame, lane reduction, round and saturate.
// Last tap at cycle T gives y_valid at T+MAC_NUM+3; taps offered during REDUCE/OUT are dropped and flagged.
module fir_mac_accumulator #(
  parameter int MAC_SIZE    = 255,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16,
  parameter int MAC_NUM     = 1,
  parameter int OUT_SIZE    = 16,
  parameter int SHIFT       = 15
) (
  input logic                  clk,
  input logic                  rst,
  fir_mac_accumulator_if.slave bus
);
  localparam int PROD_W = SAMPLE_SIZE + COEFF_SIZE;
  localparam int ACC_W  = PROD_W + $clog2(MAC_SIZE * MAC_NUM) + 1;
  localparam int TAP_W  = $clog2(MAC_SIZE) + 1;
  localparam int RED_W  = $clog2(MAC_NUM + 1);
  localparam int RSH    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'((SHIFT > 0) ? 1 : 0) << RSH;
  localparam logic signed [ACC_W:0] Y_MAX = {{(ACC_W+2-OUT_SIZE){1'b0}}, {(OUT_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W:0] Y_MIN = {{(ACC_W+2-OUT_SIZE){1'b1}}, {(OUT_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_REDUCE, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic [TAP_W-1:0]           tap_cnt_q, tap_cnt_d;
  logic [RED_W-1:0]           red_cnt_q, red_cnt_d;
  logic signed [PROD_W-1:0]   prod_q [MAC_NUM];
  logic signed [PROD_W-1:0]   prod_d [MAC_NUM];
  logic                       prod_vld_q, prod_vld_d;
  logic                       prod_first_q, prod_first_d;
  logic signed [ACC_W-1:0]    acc_q [MAC_NUM];
  logic signed [ACC_W-1:0]    acc_d [MAC_NUM];
  logic signed [ACC_W-1:0]    sum_q, sum_d;
  logic                       ch_q, ch_d;
  logic                       lerr_q, lerr_d;
  logic                       busy_q, busy_d;
  logic                       y_valid_q, y_valid_d;
  logic [OUT_SIZE-1:0]        y_out_q, y_out_d;
  logic                       y_ch_q, y_ch_d;
  logic                       len_err_q, len_err_d;
  logic                       overrun_q, overrun_d;

  logic                          take, first, at_max, last;
  logic signed [SAMPLE_SIZE-1:0] s_lane [MAC_NUM];
  logic signed [COEFF_SIZE-1:0]  c_lane [MAC_NUM];
  logic signed [ACC_W-1:0]       lane_acc;
  logic signed [ACC_W:0]         rounded, shifted;

  always_comb begin
    state_d      = state_q;
    tap_cnt_d    = tap_cnt_q;
    red_cnt_d    = red_cnt_q;
    prod_d       = prod_q;
    acc_d        = acc_q;
    prod_vld_d   = 1'b0;
    prod_first_d = 1'b0;
    sum_d        = sum_q;
    ch_d         = ch_q;
    lerr_d       = lerr_q;
    y_valid_d    = 1'b0;
    y_out_d      = y_out_q;
    y_ch_d       = y_ch_q;
    len_err_d    = len_err_q;
    overrun_d    = 1'b0;
    lane_acc     = '0;

    take   = bus.in_valid && (state_q == S_IDLE || state_q == S_ACC);
    first  = take && (state_q == S_IDLE);
    at_max = (tap_cnt_q == TAP_W'(MAC_SIZE - 1));
    last   = take && (bus.in_last || at_max);

    // Stage 1 registers products; stage 2 folds them in one cycle later, loading on a frame's first tap.
    for (int k = 0; k < MAC_NUM; k++) begin
      s_lane[k] = bus.s_in[k*SAMPLE_SIZE +: SAMPLE_SIZE];
      c_lane[k] = bus.c_in[k*COEFF_SIZE +: COEFF_SIZE];
      if (take) prod_d[k] = PROD_W'(s_lane[k]) * PROD_W'(c_lane[k]);
      if (prod_vld_q) acc_d[k] = prod_first_q ? ACC_W'(prod_q[k]) : acc_q[k] + ACC_W'(prod_q[k]);
      if (int'(red_cnt_q) == k + 1) lane_acc = acc_q[k];
    end

    if (take) begin
      prod_vld_d   = 1'b1;
      prod_first_d = first;
      if (first) ch_d = bus.in_ch;
      if (last) begin
        state_d   = S_REDUCE;
        tap_cnt_d = '0;
        red_cnt_d = '0;
        lerr_d    = bus.in_last ^ at_max;
      end else begin
        state_d   = S_ACC;
        tap_cnt_d = tap_cnt_q + TAP_W'(1);
      end
    end

    rounded = $signed({sum_q[ACC_W-1], sum_q}) + RND;
    shifted = rounded >>> SHIFT;

    // REDUCE step 0 waits for stage 2 to absorb the final tap, then lanes are summed in order.
    case (state_q)
      S_REDUCE: begin
        overrun_d = bus.in_valid;
        sum_d     = (red_cnt_q == '0) ? '0 : sum_q + lane_acc;
        if (red_cnt_q == RED_W'(MAC_NUM)) begin
          state_d   = S_OUT;
          red_cnt_d = '0;
        end else begin
          red_cnt_d = red_cnt_q + RED_W'(1);
        end
      end
      S_OUT: begin
        overrun_d = bus.in_valid;
        y_valid_d = 1'b1;
        y_ch_d    = ch_q;
        len_err_d = lerr_q;
        state_d   = S_IDLE;
        if (shifted > Y_MAX)      y_out_d = Y_MAX[OUT_SIZE-1:0];
        else if (shifted < Y_MIN) y_out_d = Y_MIN[OUT_SIZE-1:0];
        else                      y_out_d = shifted[OUT_SIZE-1:0];
      end
      default: ;
    endcase

    busy_d = first || (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tap_cnt_q    <= '0;
      red_cnt_q    <= '0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      sum_q        <= '0;
      ch_q         <= 1'b0;
      lerr_q       <= 1'b0;
      busy_q       <= 1'b0;
      y_valid_q    <= 1'b0;
      y_out_q      <= '0;
      y_ch_q       <= 1'b0;
      len_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < MAC_NUM; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      tap_cnt_q    <= tap_cnt_d;
      red_cnt_q    <= red_cnt_d;
      prod_vld_q   <= prod_vld_d;
      prod_first_q <= prod_first_d;
      sum_q        <= sum_d;
      ch_q         <= ch_d;
      lerr_q       <= lerr_d;
      busy_q       <= busy_d;
      y_valid_q    <= y_valid_d;
      y_out_q      <= y_out_d;
      y_ch_q       <= y_ch_d;
      len_err_q    <= len_err_d;
      overrun_q    <= overrun_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_out   = y_out_q;
  assign bus.y_ch    = y_ch_q;
  assign bus.len_err = len_err_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_fir_mac_accumulator.sv
// Bench for fir_mac_accumulator: two-lane, 4-tap frames, one bit of rounding shift.
// A frame-level model predicts every output each cycle; directed frames carry hand-computed results.
module tb_fir_mac_accumulator;
  localparam int MAC_SIZE    = 4;
  localparam int COEFF_SIZE  = 16;
  localparam int SAMPLE_SIZE = 16;
  localparam int MAC_NUM     = 2;
  localparam int OUT_SIZE    = 16;
  localparam int SHIFT       = 1;

  logic clk = 1'b0;
  logic rst;

  fir_mac_accumulator_if #(.SAMPLE_SIZE(SAMPLE_SIZE), .COEFF_SIZE(COEFF_SIZE),
                           .MAC_NUM(MAC_NUM), .OUT_SIZE(OUT_SIZE)) bus ();

  fir_mac_accumulator #(.MAC_SIZE(MAC_SIZE), .COEFF_SIZE(COEFF_SIZE), .SAMPLE_SIZE(SAMPLE_SIZE),
                        .MAC_NUM(MAC_NUM), .OUT_SIZE(OUT_SIZE), .SHIFT(SHIFT))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_edge = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint expect_out(input longint s);
    longint r;
    r = s;
    if (SHIFT > 0) r = r + (longint'(1) <<< (SHIFT - 1));
    r = r >>> SHIFT;
    if (r > (longint'(1) <<< (OUT_SIZE - 1)) - 1) r = (longint'(1) <<< (OUT_SIZE - 1)) - 1;
    if (r < -(longint'(1) <<< (OUT_SIZE - 1)))    r = -(longint'(1) <<< (OUT_SIZE - 1));
    return r;
  endfunction

  // Frame-level model: collects taps, and once a frame closes schedules its result for a fixed edge.
  bit     m_in_frame, m_pend, m_ch, m_win, m_res_ch, m_res_lerr;
  int     m_len, m_out_edge;
  longint m_acc, m_res;
  bit     e_busy, e_yv, e_ovr, e_ch, e_lerr;
  longint e_y;

  initial begin
    m_in_frame = 0; m_pend = 0; m_len = 0; m_acc = 0; m_out_edge = 0;
    e_busy = 0; e_yv = 0; e_ovr = 0; e_ch = 0; e_lerr = 0; e_y = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_in_frame = 0; m_pend = 0;
        e_busy = 0; e_yv = 0; e_ovr = 0; e_ch = 0; e_lerr = 0; e_y = 0;
      end else begin
        m_win = m_pend && (cyc <= m_out_edge);
        e_yv  = m_pend && (cyc == m_out_edge);
        if (e_yv) begin
          e_y = m_res; e_ch = m_res_ch; e_lerr = m_res_lerr;
        end
        e_ovr = bus.in_valid && m_win;
        if (m_pend && !m_win) m_pend = 0;
        if (bus.in_valid && !m_win) begin
          if (!m_in_frame) begin
            m_in_frame = 1; m_len = 0; m_acc = 0; m_ch = bus.in_ch;
          end
          for (int k = 0; k < MAC_NUM; k++)
            m_acc += longint'($signed(bus.s_in[k*SAMPLE_SIZE +: SAMPLE_SIZE])) *
                     longint'($signed(bus.c_in[k*COEFF_SIZE +: COEFF_SIZE]));
          m_len++;
          if (bus.in_last || m_len == MAC_SIZE) begin
            m_res      = expect_out(m_acc);
            m_res_ch   = m_ch;
            m_res_lerr = !(bus.in_last && m_len == MAC_SIZE);
            m_pend     = 1;
            // y_valid is sampled MAC_NUM+3 edges after the closing tap, so it is registered one edge earlier.
            m_out_edge = cyc + MAC_NUM + 3 - 1;
            m_in_frame = 0;
          end
        end
        e_busy = m_in_frame || m_pend;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy",    longint'(bus.busy),    longint'(e_busy));
      check("y_valid", longint'(bus.y_valid), longint'(e_yv));
      check("overrun", longint'(bus.overrun), longint'(e_ovr));
      check("y_out",   longint'($signed(bus.y_out)), e_y);
      check("y_ch",    longint'(bus.y_ch),    longint'(e_ch));
      check("len_err", longint'(bus.len_err), longint'(e_lerr));
    end
  end

  task automatic tap(input int s0, input int c0, input int s1, input int c1,
                     input bit last, input bit ch);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.in_ch    = ch;
    bus.s_in     = {16'(s1), 16'(s0)};
    bus.c_in     = {16'(c1), 16'(c0)};
    if (last) last_edge = cyc + 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_y(input string name, input longint y, input bit ch, input bit lerr);
    bit seen;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.y_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no y_valid within 20 cycles, expected y_out %0d", name, y);
    end else begin
      check({name, "_latency"}, longint'(cyc + 1 - last_edge), 5);
      check({name, "_y"},       longint'($signed(bus.y_out)), y);
      check({name, "_ch"},      longint'(bus.y_ch), longint'(ch));
      check({name, "_len_err"}, longint'(bus.len_err), longint'(lerr));
    end
  endtask

  int yv_cnt;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_ch = 1'b0;
    bus.s_in = '0; bus.c_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",    longint'(bus.busy),    0);
    check("reset_y_valid", longint'(bus.y_valid), 0);
    check("reset_y_out",   longint'(bus.y_out),   0);
    check("reset_overrun", longint'(bus.overrun), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    idle(2);

    // 1+2+3+4 = 10 -> (10+1)>>1 = 5
    tap(1, 1, 0, 0, 0, 1); tap(2, 1, 0, 0, 0, 1); tap(3, 1, 0, 0, 0, 1); tap(4, 1, 0, 0, 1, 1);
    wait_y("ramp", 5, 1, 0);
    idle(2);

    // lane0 3 + lane1 60 = 63 -> 32
    tap(1, 1, 10, 2, 0, 0); tap(2, 1, 20, 2, 0, 0); tap(0, 0, 0, 0, 0, 0); tap(0, 0, 0, 0, 1, 0);
    wait_y("two_lane", 32, 0, 0);
    idle(2);

    // single-tap frames: 3 -> 2, -3 -> -1 (half rounds up)
    tap(3, 1, 0, 0, 1, 1);
    wait_y("round_pos", 2, 1, 1);
    idle(1);
    tap(-3, 1, 0, 0, 1, 0);
    wait_y("round_neg", -1, 0, 1);
    idle(2);

    for (int i = 0; i < 4; i++) tap(32767, 32767, 32767, 32767, (i == 3), 1);
    wait_y("sat_pos", 32767, 1, 0);
    idle(2);
    for (int i = 0; i < 4; i++) tap(-32768, 32767, -32768, 32767, (i == 3), 0);
    wait_y("sat_neg", -32768, 0, 0);
    idle(2);

    // short frame: 10+10 = 20 -> 10
    tap(5, 2, 0, 0, 0, 1); tap(5, 2, 0, 0, 1, 1);
    wait_y("short", 10, 1, 1);
    idle(2);

    // forced end after 4 taps; in_last without in_valid mid-frame is ignored
    tap(1, 1, 0, 0, 0, 0); tap(1, 1, 0, 0, 0, 0);
    bus.in_valid = 1'b0; bus.in_last = 1'b1;
    @(negedge clk);
    tap(1, 1, 0, 0, 0, 0); tap(1, 1, 0, 0, 0, 0);
    last_edge = cyc;
    wait_y("forced", 2, 0, 1);
    idle(2);

    // taps offered during reduction are dropped: 28 -> 14
    for (int i = 0; i < 4; i++) tap(7, 1, 0, 0, (i == 3), 1);
    tap(100, 100, 100, 100, 0, 0);
    check("overrun_pulse", longint'(bus.overrun), 1);
    tap(100, 100, 100, 100, 0, 0);
    wait_y("overrun_frame", 14, 1, 0);

    // next frame starts right after y_valid: 24 -> 12, no carry-over
    for (int i = 0; i < 4; i++) tap(2, 3, 0, 0, (i == 3), 0);
    wait_y("back_to_back", 12, 0, 0);
    idle(2);

    // reset mid-frame discards it
    tap(1, 1, 0, 0, 0, 1); tap(1, 1, 0, 0, 0, 1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy",  longint'(bus.busy),  0);
    check("midrst_y_out", longint'(bus.y_out), 0);
    yv_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.y_valid) yv_cnt++;
    end
    check("midrst_no_y_valid", longint'(yv_cnt), 0);

    // lane0 4 + lane1 8 = 12 -> 6
    for (int i = 0; i < 4; i++) tap(1, 1, 1, 2, (i == 3), 0);
    wait_y("after_reset", 6, 0, 0);
    idle(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
